// File: rtl/store_data_formatter.sv
// Store write-data formatter: builds lane-replicated data and byte enables for a store
// request and runs the MOV/MOC write handshake, splitting doublewords into two word beats.
module store_data_formatter #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        START,
    input  logic [31:0] ADDR,
    input  logic [31:0] D,
    input  logic [31:0] DH,
    input  logic [1:0]  dataSize,
    input  logic        MOC,
    output logic        MOV,
    output logic [31:0] MADDR,
    output logic [31:0] MDATA,
    output logic [3:0]  BE,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] BEAT0 = 3'd1;
    localparam logic [2:0] GAP   = 3'd2;
    localparam logic [2:0] BEAT1 = 3'd3;
    localparam logic [2:0] FIN   = 3'd4;
    localparam logic [2:0] FAULT = 3'd5;

    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

    logic [2:0]      state;
    logic [TO_W-1:0] cnt;
    logic [31:0]     dh_q;
    logic            dword_q;

    logic            aligned;
    logic [31:0]     lane_data;
    logic [3:0]      lane_be;

    // Beat-0 lanes and the alignment check, decoded straight from the request inputs.
    always_comb begin
        aligned   = 1'b1;
        lane_data = D;
        lane_be   = 4'b1111;
        case (dataSize)
            2'b00: begin
                lane_data = {4{D[7:0]}};
                lane_be   = 4'b0001 << ADDR[1:0];
            end
            2'b01: begin
                aligned   = ~ADDR[0];
                lane_data = {2{D[15:0]}};
                lane_be   = ADDR[1] ? 4'b1100 : 4'b0011;
            end
            default: aligned = (ADDR[1:0] == 2'b00);
        endcase
    end

    // NOTE: all state and outputs update with non-blocking assignments so every
    // register samples pre-edge values, keeping the outputs cleanly registered.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state   <= IDLE;
            cnt     <= '0;
            dh_q    <= '0;
            dword_q <= 1'b0;
            MOV     <= 1'b0;
            MADDR   <= '0;
            MDATA   <= '0;
            BE      <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            ERR     <= 1'b0;
        end else begin
            DONE <= 1'b0;
            ERR  <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        BUSY    <= 1'b1;
                        dh_q    <= DH;
                        dword_q <= (dataSize == 2'b11);
                        if (aligned) begin
                            state <= BEAT0;
                            cnt   <= '0;
                            MOV   <= 1'b1;
                            MADDR <= {ADDR[31:2], 2'b00};
                            MDATA <= lane_data;
                            BE    <= lane_be;
                        end else begin
                            state <= FAULT;
                            DONE  <= 1'b1;
                            ERR   <= 1'b1;
                        end
                    end
                end
                BEAT0, BEAT1: begin
                    if (MOC) begin
                        MOV <= 1'b0;
                        BE  <= '0;
                        if (state == BEAT0 && dword_q) begin
                            state <= GAP;
                        end else begin
                            state <= FIN;
                            DONE  <= 1'b1;
                        end
                    end else if (cnt == CNT_LAST) begin
                        // Memory never answered: abandon the beat and report an error.
                        MOV   <= 1'b0;
                        BE    <= '0;
                        state <= FAULT;
                        DONE  <= 1'b1;
                        ERR   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    state <= BEAT1;
                    cnt   <= '0;
                    MOV   <= 1'b1;
                    MADDR <= MADDR + 32'd4;
                    MDATA <= dh_q;
                    BE    <= 4'b1111;
                end
                FIN, FAULT: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    MOV   <= 1'b0;
                    BE    <= '0;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_data_formatter.sv
// Self-checking bench for store_data_formatter: expected write beats are queued when a
// request is driven and popped as the DUT presents them to the modelled memory.
module tb_store_data_formatter;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } beat_t;

    logic        CLK = 1'b0;
    logic        CLR = 1'b0;
    logic        START = 1'b0;
    logic [31:0] ADDR = '0;
    logic [31:0] D = '0;
    logic [31:0] DH = '0;
    logic [1:0]  dataSize = '0;
    logic        MOC = 1'b0;
    logic        MOV;
    logic [31:0] MADDR;
    logic [31:0] MDATA;
    logic [3:0]  BE;
    logic        BUSY;
    logic        DONE;
    logic        ERR;

    int    n_cmp = 0;
    int    n_err = 0;
    beat_t exp_q[$];

    store_data_formatter #(.TIMEOUT(16), .TO_W(5)) dut (
        .CLK(CLK), .CLR(CLR), .START(START), .ADDR(ADDR), .D(D), .DH(DH),
        .dataSize(dataSize), .MOC(MOC), .MOV(MOV), .MADDR(MADDR), .MDATA(MDATA),
        .BE(BE), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    task automatic start_txn(input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] dh, input logic [1:0] sz);
        @(negedge CLK);
        START    = 1'b1;
        ADDR     = a;
        D        = d;
        DH       = dh;
        dataSize = sz;
    endtask

    // Plays memory for one request: answers each beat after moc_delay wait cycles
    // (negative = never), optionally re-pulses START at poke_cyc, then checks the outcome.
    task automatic run_txn(input string name, input int moc_delay, input int poke_cyc,
                           input int exp_mov, input int exp_done_cyc, input logic exp_err);
        int    mov_cycles = 0;
        int    wait_cnt = 0;
        int    done_cyc = 0;
        int    done_count = 0;
        logic  beat_active = 1'b0;
        logic  seen_err = 1'b0;
        beat_t cur = '0;
        beat_t e;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge CLK);
            START = (cyc == poke_cyc);
            if (cyc == poke_cyc) ADDR = 32'h0000_0001;
            if (MOV === 1'b1) begin
                if (!beat_active) begin
                    beat_active = 1'b1;
                    wait_cnt    = 0;
                    cur         = '{MADDR, MDATA, BE};
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL %s beat: unexpected beat %h/%h/%b", name, MADDR, MDATA, BE);
                    end else begin
                        e = exp_q.pop_front();
                        if (cur !== e) begin
                            n_err++;
                            $display("FAIL %s beat: got %h/%h/%b want %h/%h/%b", name,
                                     cur.addr, cur.data, cur.be, e.addr, e.data, e.be);
                        end
                    end
                end else begin
                    n_cmp++;
                    if ({MADDR, MDATA, BE} !== cur) begin
                        n_err++;
                        $display("FAIL %s hold: got %h/%h/%b want %h/%h/%b", name,
                                 MADDR, MDATA, BE, cur.addr, cur.data, cur.be);
                    end
                end
                mov_cycles++;
                MOC = (moc_delay >= 0) && (wait_cnt >= moc_delay);
                wait_cnt++;
            end else begin
                beat_active = 1'b0;
                MOC         = 1'b0;
                n_cmp++;
                if (BE !== 4'b0000) begin
                    n_err++;
                    $display("FAIL %s be_idle: got %b want 0000", name, BE);
                end
            end
            if (DONE === 1'b1) begin
                done_count++;
                if (done_cyc == 0) done_cyc = cyc;
                seen_err = ERR;
            end else if (done_cyc != 0) begin
                n_cmp++;
                if (BUSY !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s busy_after: got %b want 0", name, BUSY);
                end
                break;
            end
        end
        MOC = 1'b0;
        n_cmp++;
        if (done_count != 1) begin
            n_err++;
            $display("FAIL %s done_count: got %0d want 1 (cycle budget may have expired)", name, done_count);
        end
        n_cmp++;
        if (done_cyc != exp_done_cyc) begin
            n_err++;
            $display("FAIL %s done_cycle: got %0d want %0d", name, done_cyc, exp_done_cyc);
        end
        n_cmp++;
        if (seen_err !== exp_err) begin
            n_err++;
            $display("FAIL %s err: got %b want %b", name, seen_err, exp_err);
        end
        n_cmp++;
        if (mov_cycles != exp_mov) begin
            n_err++;
            $display("FAIL %s mov_cycles: got %0d want %0d", name, mov_cycles, exp_mov);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s leftover: %0d beats never issued, want 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({MOV, MADDR, MDATA, BE, BUSY, DONE, ERR} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got MOV=%b MADDR=%h MDATA=%h BE=%b BUSY=%b DONE=%b ERR=%b want all 0",
                     MOV, MADDR, MDATA, BE, BUSY, DONE, ERR);
        end
        @(negedge CLK);
        CLR = 1'b1;
    endtask

    task automatic test_byte();
        exp_q.push_back('{32'h0000_1000, 32'h0303_0303, 4'b1000});
        start_txn(32'h0000_1003, 32'h0000_FF03, '0, 2'b00);
        run_txn("byte", 0, 0, 1, 2, 1'b0);
        for (int a = 0; a < 4; a++) begin
            exp_q.push_back('{32'h0000_5000, 32'hA5A5_A5A5, 4'b0001 << a});
            start_txn(32'h0000_5000 + 32'(a), 32'h1234_56A5, '0, 2'b00);
            run_txn("byte_lane", a, 0, a + 1, a + 2, 1'b0);
        end
    endtask

    task automatic test_half();
        exp_q.push_back('{32'h0000_2000, 32'h7492_7492, 4'b1100});
        start_txn(32'h0000_2002, 32'hF0E4_7492, '0, 2'b01);
        run_txn("half_hi", 0, 0, 1, 2, 1'b0);
        exp_q.push_back('{32'h0000_2000, 32'h7492_7492, 4'b0011});
        start_txn(32'h0000_2000, 32'hF0E4_7492, '0, 2'b01);
        run_txn("half_lo", 1, 0, 2, 3, 1'b0);
        start_txn(32'h0000_2001, 32'hF0E4_7492, '0, 2'b01);
        run_txn("half_misaligned", 0, 0, 0, 1, 1'b1);
        start_txn(32'h0000_2002, 32'hF0E4_7492, '0, 2'b10);
        run_txn("word_misaligned", 0, 0, 0, 1, 1'b1);
    endtask

    task automatic test_dword();
        exp_q.push_back('{32'h0000_3000, 32'hF0E4_7492, 4'b1111});
        exp_q.push_back('{32'h0000_3004, 32'h0000_FF03, 4'b1111});
        start_txn(32'h0000_3000, 32'hF0E4_7492, 32'h0000_FF03, 2'b11);
        run_txn("dword", 3, 0, 8, 10, 1'b0);
    endtask

    task automatic test_timeout();
        exp_q.push_back('{32'h0000_6000, 32'hDEAD_BEEF, 4'b1111});
        start_txn(32'h0000_6000, 32'hDEAD_BEEF, '0, 2'b10);
        run_txn("timeout_stuck", -1, 0, 16, 17, 1'b1);
        exp_q.push_back('{32'h0000_6000, 32'hDEAD_BEEF, 4'b1111});
        start_txn(32'h0000_6000, 32'hDEAD_BEEF, '0, 2'b10);
        run_txn("timeout_edge", 15, 0, 16, 17, 1'b0);
    endtask

    task automatic test_busy_ignore();
        exp_q.push_back('{32'h0000_7000, 32'hCAFE_F00D, 4'b1111});
        start_txn(32'h0000_7000, 32'hCAFE_F00D, '0, 2'b10);
        run_txn("busy_ignore", 5, 3, 6, 7, 1'b0);
    endtask

    task automatic test_reset_mid_beat();
        start_txn(32'h0000_4000, 32'h1111_1111, 32'h2222_2222, 2'b11);
        @(negedge CLK);
        START = 1'b0;
        MOC   = 1'b1;
        @(negedge CLK);
        MOC = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if ({MOV, MADDR, MDATA} !== {1'b1, 32'h0000_4004, 32'h2222_2222}) begin
            n_err++;
            $display("FAIL rst_pre_beat1: got MOV=%b %h/%h want 1 00004004/22222222", MOV, MADDR, MDATA);
        end
        #2 CLR = 1'b0;
        #1;
        n_cmp++;
        if ({MOV, BE, BUSY, DONE} !== '0) begin
            n_err++;
            $display("FAIL rst_mid_beat: got MOV=%b BE=%b BUSY=%b DONE=%b want all 0", MOV, BE, BUSY, DONE);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            n_cmp++;
            if (DONE !== 1'b0 || MOV !== 1'b0) begin
                n_err++;
                $display("FAIL rst_hold: got DONE=%b MOV=%b want 0 0", DONE, MOV);
            end
        end
        CLR = 1'b1;
        exp_q.push_back('{32'h0000_1000, 32'h0303_0303, 4'b1000});
        start_txn(32'h0000_1003, 32'h0000_FF03, '0, 2'b00);
        run_txn("byte_after_reset", 0, 0, 1, 2, 1'b0);
    endtask

    task automatic test_wrap();
        exp_q.push_back('{32'hFFFF_FFFC, 32'h0BAD_F00D, 4'b1111});
        exp_q.push_back('{32'h0000_0000, 32'h600D_CAFE, 4'b1111});
        start_txn(32'hFFFF_FFFC, 32'h0BAD_F00D, 32'h600D_CAFE, 2'b11);
        run_txn("wrap", 0, 0, 2, 4, 1'b0);
    endtask

    initial begin
        test_reset();
        test_byte();
        test_half();
        test_dword();
        test_timeout();
        test_busy_ignore();
        test_reset_mid_beat();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
